// File: rtl/fifo_rd_stream_adapter.sv
// fifo_rd_stream_adapter: drains a 1-cycle-latency synchronous FIFO into a
// valid/ready stream through a 2-entry skid buffer, so the stream can carry
// one beat per clock. Also provides a sync flush and an accepted-beat counter.
module fifo_rd_stream_adapter #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  flush,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  beat_cnt,
  output logic                  busy
);

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  logic [1:0]            r_occ;
  logic                  r_inflight;
  logic                  r_head;
  logic [DATA_WIDTH-1:0] r_mem [2];
  logic [CNT_WIDTH-1:0]  r_beat_cnt;

  logic                  w_pop;
  logic                  w_capture;
  logic                  w_tail;
  logic [2:0]            w_credit_use;

  assign w_pop     = m_valid && m_ready;
  // Returning data in a flush cycle is dropped along with the buffer.
  assign w_capture = r_inflight && !flush;
  // Tail is head when empty, the other slot when one entry is held.
  assign w_tail    = r_head ^ (r_occ == OCC_ONE);

  // Entries held plus the one in flight, minus the one leaving this cycle.
  // Including the pop lets a read issue every cycle while the consumer drains.
  assign w_credit_use = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign fifo_rd_en   = !fifo_empty && !flush && !rst && (w_credit_use < 3'd2);

  assign m_valid  = (r_occ != OCC_EMPTY);
  assign m_data   = m_valid ? r_mem[r_head] : '0;
  assign busy     = m_valid || r_inflight;
  assign beat_cnt = r_beat_cnt;

  // Occupancy, head pointer and read-in-flight tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ      <= OCC_EMPTY;
      r_head     <= 1'b0;
      r_inflight <= 1'b0;
    end else if (flush) begin
      r_occ      <= OCC_EMPTY;
      r_head     <= 1'b0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= fifo_rd_en;
      case ({w_capture, w_pop})
        2'b10: r_occ <= r_occ + 2'd1;
        2'b01: begin
          r_occ  <= r_occ - 2'd1;
          r_head <= ~r_head;
        end
        2'b11: r_head <= ~r_head;
        default: ;
      endcase
    end
  end

  // Skid storage: FIFO read data lands in the tail slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
    end else if (w_capture) begin
      r_mem[w_tail] <= fifo_rdata;
    end
  end

  // Accepted-beat counter; a pop in a flush cycle still counts, flush never clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_beat_cnt <= '0;
    else if (w_pop) r_beat_cnt <= r_beat_cnt + 1'b1;
  end

  // The credit rule must never let a capture land on a full buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_capture && !w_pop && (r_occ == OCC_TWO)));

endmodule
